pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Upstream neighbour of the instruction controller: owns the program counter, computes next PC from PCsel1/PCsel0, fetches from instruction memory over a req/ack handshake, and holds the fetched word in an instruction register (IR).
- Drives the decoded opcode, lorbtype and alu_action fields consumed by the controller.
- opcode reads 0 while a fetch is in flight, so the controller's nonzero-opcode check in S0/S1 naturally waits for the fetch.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_VECTOR, 32'h0000_0000, PC value selected by PCsel=11.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enPC  in  1  PC update strobe from the controller, sampled at posedge.
- PCsel1  in  1  next-PC select, MSB.
- PCsel0  in  1  next-PC select, LSB.
- imm  in  XLEN  sign-extended immediate (B/J/I) from the immediate generator.
- rs1_data  in  XLEN  register-file rs1 value, used for jalr.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, equals pc while imem_req is high.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word.
- pc  out  XLEN  current PC.
- pc_plus4  out  XLEN  pc+4, the link value for jal/jalr.
- instr  out  32  IR contents.
- instr_valid  out  1  IR holds the word fetched from the current pc.
- opcode  out  7  instr[6:0].
- lorbtype  out  3  instr[14:12].
- alu_action  out  4  {instr[30], instr[14:12]}.
- misalign_err  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_VECTOR; IR=0; instr_valid=0; imem_req=0; misalign_err=0; state=IDLE; redirect flag cleared.
  - Any in-flight request is dropped immediately; an ack arriving after reset is ignored.
- Next PC (combinational, arithmetic modulo 2^XLEN):
  - 00: pc+4.
  - 01: pc+imm.
  - 10: (rs1_data+imm) & ~1.
  - 11: RESET_VECTOR.
- FSM states: IDLE, FETCH, DONE.
  - IDLE: imem_req=0. On enPC=1 at posedge: pc<=target, IR<=0, instr_valid<=0, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On ack, with redirect flag clear: IR<=imem_rdata, instr_valid<=1, go to DONE. Request-to-IR latency is at least 1 cycle; an ack in the first FETCH cycle latches on that edge.
  - DONE: imem_req=0; IR and fields hold. On enPC=1: same action as in IDLE.
- enPC during FETCH (redirect):
  - pc<=target at once.
  - The current request stays asserted at the old address until its ack (imem_addr must not change mid-request), and the returned data is discarded.
  - The next cycle issues a new request to the new pc.
  - enPC in the same cycle as imem_ack: the data is discarded and a fetch to the new target follows.
- Misalignment: a target with bits[1:0]≠00 sets misalign_err (sticky until rst). PC is not updated, no fetch starts, and the state is unchanged.
- The controller holds enPC high exactly one cycle per PC update. A multi-cycle enPC counts as one update per cycle; this is legal but unintended.
- Output timing: fields are pure slices of IR, so they are 0 whenever IR=0. pc_plus4 is combinational from pc.

Optional Feature:
- MISALIGN_CHECK_EN
  - Defined: misalign_err behaviour as above.
  - Undefined: target bits[1:0] are forced to 00 and used; misalign_err is tied to 0.

Decomposition:
- Shared package:
  - pc_sel encoding constants: PCSEL_SEQ=2'b00, PCSEL_BR=2'b01, PCSEL_JALR=2'b10, PCSEL_RST=2'b11.
  - Opcode constants shared with the controller.
  - Fetch FSM state typedef.
- One natural sub-module: next_pc_mux (combinational target computation plus the alignment check).

Test Plan:
- Reset then enPC with sel=11, RESET_VECTOR=0: imem_addr=0, imem_req=1; ack with 32'h00500093 one cycle later → opcode=7'h13, lorbtype=0, alu_action=0, instr_valid=1, imem_req=0.
- pc=0x100, enPC with sel=00 → pc=0x104 and fetch at 0x104; sel=01 with imm=-8 → pc=0xFC.
- sel=10, rs1_data=0x203, imm=4 → pc=0x206 with MISALIGN_CHECK_EN undefined (0x204); with it defined, misalign_err=1 and pc unchanged.
- Redirect: enPC sel=01 at 0x40 while a fetch to 0x10 is pending with ack delayed 3 cycles → 0x10 data discarded, then new req at 0x40, IR loads only the 0x40 word.
- rst asserted mid-FETCH with a late ack pulse → imem_req drops asynchronously, IR stays 0, pc=RESET_VECTOR.
- While a fetch waits 5 cycles for ack → opcode=0 throughout; imem_addr is stable.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: next-PC select codes, shared opcodes and fetch FSM states
package pc_fetch_unit_pkg;
  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_JALR = 2'b10;
  localparam logic [1:0] PCSEL_RST  = 2'b11;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_t;
endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// pc_fetch_unit_next_pc_mux: next-PC target and alignment check (MISALIGN_CHECK_EN flags instead of masking)
module pc_fetch_unit_next_pc_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [1:0]      sel,
  output logic [XLEN-1:0] target,
  output logic            misalign
);
  logic [XLEN-1:0] raw;
  always_comb begin
    raw = sel == PCSEL_SEQ  ? pc + XLEN'(4) :
          sel == PCSEL_BR   ? pc + imm :
          sel == PCSEL_JALR ? (rs1_data + imm) & ~XLEN'(1) :
                              RESET_VECTOR;
  end
`ifdef MISALIGN_CHECK_EN
  assign target   = raw;
  assign misalign = |raw[1:0];
`else
  assign target   = raw & ~XLEN'(3);
  assign misalign = 1'b0;
`endif
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC, next-PC selection, req/ack instruction fetch and IR (MISALIGN_CHECK_EN enables misalign_err)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enPC,
  input  logic            PCsel1,
  input  logic            PCsel0,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      lorbtype,
  output logic [3:0]      alu_action,
  output logic            misalign_err
);
  fetch_state_t state, state_nx;
  logic [XLEN-1:0] target, req_addr;
  logic misalign, upd, redirect;
  pc_fetch_unit_next_pc_mux #(.XLEN(XLEN), .RESET_VECTOR(RESET_VECTOR)) u_mux (
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .sel({PCsel1, PCsel0}),
    .target(target), .misalign(misalign)
  );
  assign upd = enPC & ~misalign;
  always_comb begin
    state_nx = state;
    if (state != FETCH)
      state_nx = upd ? FETCH : state;
    else
      state_nx = (imem_ack && !redirect && !upd) ? DONE : FETCH;
  end
  // req_addr freezes the in-flight request address across a redirect until its ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      req_addr     <= RESET_VECTOR;
      instr        <= '0;
      instr_valid  <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (enPC && misalign) misalign_err <= 1'b1;
      if (upd) pc <= target;
      if (state == FETCH) begin
        if (imem_ack) begin
          redirect <= 1'b0;
          req_addr <= upd ? target : pc;
          if (!redirect && !upd) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end
        end else if (upd) begin
          redirect <= 1'b1;
        end
      end else if (upd) begin
        req_addr    <= target;
        instr       <= '0;
        instr_valid <= 1'b0;
        redirect    <= 1'b0;
      end
    end
  end
  assign imem_req   = state == FETCH;
  assign imem_addr  = req_addr;
  assign pc_plus4   = pc + XLEN'(4);
  assign opcode     = instr[6:0];
  assign lorbtype   = instr[14:12];
  assign alu_action = {instr[30], instr[14:12]};
endmodule
